// File: rtl/simpleton_io_display_if.sv
// ---------------------------------------------------------------------------
// simpleton_io_display_if
// Memory-bus bundle from the simpleton CPU core to its display/snoop
// peripheral.
//   bus_addr  [7:0]  memory address (EndMem)
//   bus_din   [7:0]  store data (AC output)
//   bus_write        memory write strobe
//   cpu_ea    [2:0]  CPU control state, 3'b101 = HLT
// master: the CPU side (drives everything); slave: the snooper (observes).
// ---------------------------------------------------------------------------
interface simpleton_io_display_if;
    logic [7:0] bus_addr;
    logic [7:0] bus_din;
    logic       bus_write;
    logic [2:0] cpu_ea;

    modport master (
        output bus_addr,
        output bus_din,
        output bus_write,
        output cpu_ea
    );

    modport slave (
        input  bus_addr,
        input  bus_din,
        input  bus_write,
        input  cpu_ea
    );
endinterface

// File: rtl/simpleton_io_display.sv
// ---------------------------------------------------------------------------
// simpleton_io_display
// Snoops the simpleton CPU memory bus, shadows stores into the RAM window
// (addr[7]=1), counts them, tracks HLT, and drives a time-multiplexed
// 4-digit hex 7-segment display.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus (slave)     bus_addr, bus_din, bus_write, cpu_ea
//   view     [1:0]  display page select (asynchronous to the scan)
//   seg      [6:0]  shared segments {a..g}, bit6 = a
//   dp              decimal point of the enabled digit
//   an       [3:0]  one-hot digit enable, an[0] = rightmost digit
//   wr_count [7:0]  saturating RAM-window store count
//   halted          registered (cpu_ea == 3'b101)
// ---------------------------------------------------------------------------
module simpleton_io_display #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    simpleton_io_display_if.slave  bus,
    input  logic [1:0]             view,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [3:0]             an,
    output logic [7:0]             wr_count,
    output logic                   halted
);

    localparam logic [19:0] PRE_TC  = 20'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0]  AN_INV  = {4{AN_ACTIVE_LOW}};
    localparam logic [2:0]  EA_HLT  = 3'b101;

    // Hex digit to abcdefg, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
            4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
            4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  4'hF: s = 7'h47;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [7:0]  r_slot [4];
    logic [7:0]  r_last_addr;
    logic [7:0]  r_last_data;
    logic [7:0]  r_wr_count;
    logic        r_halted;
    logic [19:0] r_pre;
    logic [1:0]  r_idx;
    logic [1:0]  r_view_meta;
    logic [1:0]  r_view_sync;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic [3:0]  r_an;

    logic        w_cap;
    logic        w_tc;
    logic [1:0]  w_idx_nxt;
    logic [15:0] w_page;
    logic [3:0]  w_nib;
    logic [3:0]  w_an_dec;

    // Refresh decode: page word, digit nibble and one-hot enable for the next digit.
    always_comb begin
        w_cap     = bus.bus_write & bus.bus_addr[7];
        w_tc      = (r_pre == PRE_TC);
        w_idx_nxt = r_idx + 2'd1;
        case (r_view_sync)
            2'd0:    w_page = {r_last_addr, r_last_data};
            2'd1:    w_page = {r_slot[1], r_slot[0]};
            2'd2:    w_page = {r_slot[3], r_slot[2]};
            2'd3:    w_page = {r_wr_count, 4'h0, 1'b0, bus.cpu_ea};
            default: w_page = 16'h0000;
        endcase
        w_nib = w_page[{w_idx_nxt, 2'b00} +: 4];
        case (w_idx_nxt)
            2'd0:    w_an_dec = 4'b0001;
            2'd1:    w_an_dec = 4'b0010;
            2'd2:    w_an_dec = 4'b0100;
            2'd3:    w_an_dec = 4'b1000;
            default: w_an_dec = 4'b0001;
        endcase
    end

    // Bus snoop: RAM-window shadow slots, last store, saturating count, halt flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= 8'h00;
            end
            r_last_addr <= 8'h00;
            r_last_data <= 8'h00;
            r_wr_count  <= 8'h00;
            r_halted    <= 1'b0;
        end else begin
            r_halted <= (bus.cpu_ea == EA_HLT);
            if (w_cap) begin
                r_slot[bus.bus_addr[1:0]] <= bus.bus_din;
                r_last_addr               <= bus.bus_addr;
                r_last_data               <= bus.bus_din;
                if (r_wr_count != 8'hFF) begin
                    r_wr_count <= r_wr_count + 8'd1;
                end
            end
        end
    end

    // Two-flop synchronizer for the asynchronous page select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_view_meta <= 2'd0;
            r_view_sync <= 2'd0;
        end else begin
            r_view_meta <= view;
            r_view_sync <= r_view_meta;
        end
    end

    // Scan prescaler, digit index and display output register.
    // seg/dp/an load together on the refresh edge from the new index; the
    // nibble comes from pre-capture register values, so a simultaneous store
    // only shows on a later refresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= 20'd0;
            r_idx <= 2'd0;
            r_seg <= 7'b1111110 ^ SEG_INV;
            r_dp  <= 1'b0 ^ SEG_ACTIVE_LOW;
            r_an  <= 4'b0001 ^ AN_INV;
        end else if (w_tc) begin
            r_pre <= 20'd0;
            r_idx <= w_idx_nxt;
            r_seg <= hex_to_seg(w_nib) ^ SEG_INV;
            r_dp  <= ((w_idx_nxt == 2'd0) & r_halted) ^ SEG_ACTIVE_LOW;
            r_an  <= w_an_dec ^ AN_INV;
        end else begin
            r_pre <= r_pre + 20'd1;
        end
    end

    assign seg      = r_seg;
    assign dp       = r_dp;
    assign an       = r_an;
    assign wr_count = r_wr_count;
    assign halted   = r_halted;

endmodule
